// File: rtl/wshb_arb_pkg.sv
// Shared types and widths for the two-requester Wishbone arbiter.
package wshb_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} arb_state_t;
  typedef logic [1:0] owner_t;

  localparam owner_t OWNER_NONE = 2'b00;
  localparam owner_t OWNER_0    = 2'b01;
  localparam owner_t OWNER_1    = 2'b10;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;
endpackage

// File: rtl/wshb_if.sv
// Wishbone classic bundle; master drives requests, slave returns ack and read data.
interface wshb_if;
  import wshb_arb_pkg::*;

  logic               cyc;
  logic               stb;
  logic               we;
  logic [ADR_W-1:0]   adr;
  logic [DAT_W-1:0]   dat_ms;
  logic [DAT_W-1:0]   dat_sm;
  logic [SEL_W-1:0]   sel;
  logic [2:0]         cti;
  logic [1:0]         bte;
  logic               ack;

  modport master (output cyc, stb, we, adr, dat_ms, sel, cti, bte,
                  input  ack, dat_sm);
  modport slave  (input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
                  output ack, dat_sm);
endinterface

// File: rtl/wshb_arb_mux.sv
// Combinational routing between the two requesters and the shared slave port.
module wshb_arb_mux
  import wshb_arb_pkg::*;
(
  input  owner_t           owner,
  input  logic [DAT_W-1:0] hold0,
  input  logic [DAT_W-1:0] hold1,
  wshb_if.slave            s0,
  wshb_if.slave            s1,
  wshb_if.master           m
);
  logic sel0;
  logic sel1;

  assign sel0 = (owner == OWNER_0);
  assign sel1 = (owner == OWNER_1);

  // With no owner every request line is forced low, so the slave sees an idle bus.
  assign m.cyc    = (sel0 & s0.cyc) | (sel1 & s1.cyc);
  assign m.stb    = (sel0 & s0.stb) | (sel1 & s1.stb);
  assign m.we     = (sel0 & s0.we)  | (sel1 & s1.we);
  assign m.adr    = sel0 ? s0.adr    : (sel1 ? s1.adr    : '0);
  assign m.dat_ms = sel0 ? s0.dat_ms : (sel1 ? s1.dat_ms : '0);
  assign m.sel    = sel0 ? s0.sel    : (sel1 ? s1.sel    : '0);
  assign m.cti    = sel0 ? s0.cti    : (sel1 ? s1.cti    : '0);
  assign m.bte    = sel0 ? s0.bte    : (sel1 ? s1.bte    : '0);

  assign s0.ack    = sel0 & m.ack;
  assign s1.ack    = sel1 & m.ack;
  assign s0.dat_sm = sel0 ? m.dat_sm : hold0;
  assign s1.dat_sm = sel1 ? m.dat_sm : hold1;
endmodule

// File: rtl/wshb_arbiter.sv
// Two-requester Wishbone arbiter with bounded bursts and a one-cycle gap between owners.
// Define WSHB_ARB_FIXED_PRIO_EN to make requester 0 always win and never be preempted.
//
//  state | meaning
//  IDLE  | no owner, arbitrate pending requests
//  OWN0  | requester 0 (reader) drives the slave
//  OWN1  | requester 1 (writer) drives the slave
//  GAP   | dead cycle with cyc low, arbitrate as in IDLE
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  wshb_if.slave      wshb_ifs0,
  wshb_if.slave      wshb_ifs1,
  wshb_if.master     wshb_ifm,
  output logic [1:0] owner
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
`ifdef WSHB_ARB_FIXED_PRIO_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  arb_state_t       state;
  owner_t           owner_q;
  logic [CNT_W-1:0] burst_cnt;
  logic             last_served;
  logic [DAT_W-1:0] hold0;
  logic [DAT_W-1:0] hold1;
  logic             req0, req1, win0, win1;
  logic             xfer, at_limit, pre0, pre1;

  assign req0     = wshb_ifs0.cyc & wshb_ifs0.stb;
  assign req1     = wshb_ifs1.cyc & wshb_ifs1.stb;
  // Forwarded stb is zero outside OWNx, so stray slave acks never count.
  assign xfer     = wshb_ifm.ack & wshb_ifm.stb;
  assign at_limit = (burst_cnt >= CNT_LAST);

  assign win0 = req0 & (~req1 | last_served | FIXED_PRIO);
  assign win1 = req1 & ~win0;
  assign pre0 = xfer & at_limit & req1 & ~FIXED_PRIO;
  assign pre1 = xfer & at_limit & req0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner_q     <= OWNER_NONE;
      burst_cnt   <= '0;
      last_served <= 1'b1;
      hold0       <= '0;
      hold1       <= '0;
    end else begin
      case (state)
        IDLE, GAP: begin
          burst_cnt <= '0;
          if (win0) begin
            state   <= OWN0;
            owner_q <= OWNER_0;
          end else if (win1) begin
            state   <= OWN1;
            owner_q <= OWNER_1;
          end else begin
            state   <= IDLE;
            owner_q <= OWNER_NONE;
          end
        end
        OWN0: begin
          hold0 <= wshb_ifm.dat_sm;
          if (!wshb_ifs0.cyc || pre0) begin
            state       <= GAP;
            owner_q     <= OWNER_NONE;
            last_served <= 1'b0;
            burst_cnt   <= '0;
          end else if (xfer && burst_cnt != CNT_MAX) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        OWN1: begin
          hold1 <= wshb_ifm.dat_sm;
          if (!wshb_ifs1.cyc || pre1) begin
            state       <= GAP;
            owner_q     <= OWNER_NONE;
            last_served <= 1'b1;
            burst_cnt   <= '0;
          end else if (xfer && burst_cnt != CNT_MAX) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          owner_q <= OWNER_NONE;
        end
      endcase
    end
  end

  assign owner = owner_q;

  wshb_arb_mux u_mux (
    .owner (owner_q),
    .hold0 (hold0),
    .hold1 (hold1),
    .s0    (wshb_ifs0),
    .s1    (wshb_ifs1),
    .m     (wshb_ifm)
  );
endmodule

// File: tb/tb_wshb_arbiter.sv
// Bench for wshb_arbiter: randomized requesters and slave against a cycle-level ownership model.
module tb_wshb_arbiter;
  import wshb_arb_pkg::*;

  localparam int MAXB = 16;
`ifdef WSHB_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] owner;

  wshb_if s0_if ();
  wshb_if s1_if ();
  wshb_if m_if ();

  wshb_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wshb_ifs0 (s0_if),
    .wshb_ifs1 (s1_if),
    .wshb_ifm  (m_if),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // requester behaviour: 0 idle, 1 continuous, 2 random, 3 fixed number of transfers
  int          mode [2];
  int          remain [2];
  int          ack_pct;
  bit          cyc_d [2];
  bit          stb_d [2];
  bit          we_d [2];
  bit          pend [2];
  logic [31:0] adr_d [2];
  logic [31:0] dat_d [2];
  logic [3:0]  sel_d [2];
  logic [2:0]  cti_d [2];
  logic [1:0]  bte_d [2];
  bit          ack_d;
  logic [31:0] sdat_d;

  // model: owner index (-1 none), acked transfers in this tenure, last served requester
  int          m_own;
  int          m_cnt;
  int          m_last;
  logic [31:0] m_hold [2];
  int          obs_acks [2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic int arb(bit r0, bit r1);
    if (r0 && r1) return FIXED ? 0 : ((m_last == 0) ? 1 : 0);
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1;
    m_cnt = 0;
    m_last = 1;
    m_hold[0] = '0;
    m_hold[1] = '0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
  endtask

  task automatic apply();
    s0_if.cyc = cyc_d[0]; s0_if.stb = stb_d[0]; s0_if.we = we_d[0];
    s0_if.adr = adr_d[0]; s0_if.dat_ms = dat_d[0]; s0_if.sel = sel_d[0];
    s0_if.cti = cti_d[0]; s0_if.bte = bte_d[0];
    s1_if.cyc = cyc_d[1]; s1_if.stb = stb_d[1]; s1_if.we = we_d[1];
    s1_if.adr = adr_d[1]; s1_if.dat_ms = dat_d[1]; s1_if.sel = sel_d[1];
    s1_if.cti = cti_d[1]; s1_if.bte = bte_d[1];
    m_if.ack = ack_d;
    m_if.dat_sm = sdat_d;
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      case (mode[i])
        1: begin cyc_d[i] = 1'b1; stb_d[i] = 1'b1; end
        2: begin
          if ($urandom_range(7) == 0) cyc_d[i] = !cyc_d[i];
          stb_d[i] = cyc_d[i] && ($urandom_range(3) != 0);
        end
        3: begin
          if (remain[i] == 0) mode[i] = 0;
          cyc_d[i] = (remain[i] > 0);
          stb_d[i] = cyc_d[i];
        end
        default: begin cyc_d[i] = 1'b0; stb_d[i] = 1'b0; end
      endcase
      if (!pend[i]) begin
        adr_d[i] = $urandom;
        dat_d[i] = $urandom;
        we_d[i]  = 1'($urandom_range(1));
        sel_d[i] = 4'($urandom);
        cti_d[i] = 3'($urandom);
        bte_d[i] = 2'($urandom);
      end
    end
    if (m_own >= 0 && cyc_d[m_own] && stb_d[m_own])
      ack_d = ($urandom_range(99) < ack_pct);
    else
      ack_d = (m_own < 0) && ($urandom_range(9) == 0);
    sdat_d = $urandom;
    apply();
  endtask

  task automatic check_outputs();
    int         o;
    logic [1:0] e_own;
    bit         e_cyc, e_stb, e_we;
    logic [31:0] e_adr, e_dat;
    logic [8:0] e_attr;
    o = m_own;
    e_own = (o == 0) ? 2'b01 : ((o == 1) ? 2'b10 : 2'b00);
    e_cyc = (o >= 0) ? cyc_d[o] : 1'b0;
    e_stb = (o >= 0) ? stb_d[o] : 1'b0;
    e_we  = (o >= 0) ? we_d[o]  : 1'b0;
    e_adr = (o >= 0) ? adr_d[o] : '0;
    e_dat = (o >= 0) ? dat_d[o] : '0;
    e_attr = (o >= 0) ? {sel_d[o], cti_d[o], bte_d[o]} : '0;
    chk("owner", 32'(owner), 32'(e_own));
    chk("m_cyc", 32'(m_if.cyc), 32'(e_cyc));
    chk("m_stb", 32'(m_if.stb), 32'(e_stb));
    chk("m_we", 32'(m_if.we), 32'(e_we));
    chk("m_adr", m_if.adr, e_adr);
    chk("m_dat_ms", m_if.dat_ms, e_dat);
    chk("m_sel_cti_bte", 32'({m_if.sel, m_if.cti, m_if.bte}), 32'(e_attr));
    chk("s0_ack", 32'(s0_if.ack), 32'((o == 0) && ack_d));
    chk("s1_ack", 32'(s1_if.ack), 32'((o == 1) && ack_d));
    chk("s0_dat_sm", s0_if.dat_sm, (o == 0) ? sdat_d : m_hold[0]);
    chk("s1_dat_sm", s1_if.dat_sm, (o == 1) ? sdat_d : m_hold[1]);
    obs_acks[0] += int'(s0_if.ack);
    obs_acks[1] += int'(s1_if.ack);
  endtask

  task automatic model_step();
    bit r0, r1, xfer, oreq, pre;
    int o;
    r0 = cyc_d[0] && stb_d[0];
    r1 = cyc_d[1] && stb_d[1];
    o = m_own;
    for (int i = 0; i < 2; i++) pend[i] = stb_d[i] && !(o == i && ack_d);
    if (o < 0) begin
      m_own = arb(r0, r1);
      m_cnt = 0;
    end else begin
      m_hold[o] = sdat_d;
      xfer = ack_d && stb_d[o];
      oreq = (o == 0) ? r1 : r0;
      pre = xfer && (m_cnt >= MAXB - 1) && oreq && !(FIXED && o == 0);
      if (xfer && mode[o] == 3 && remain[o] > 0) remain[o]--;
      if (!cyc_d[o] || pre) begin
        m_last = o;
        m_own = -1;
        m_cnt = 0;
      end else if (xfer && m_cnt < MAXB) begin
        m_cnt++;
      end
    end
  endtask

  task automatic step_body();
    drive();
    #1;
    check_outputs();
    model_step();
  endtask

  task automatic step();
    @(negedge clk);
    step_body();
  endtask

  task automatic do_reset(int hold_cycles);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_owner", 32'(owner), 32'(0));
    chk("rst_m_cyc", 32'(m_if.cyc), 32'(0));
    chk("rst_m_adr", m_if.adr, 32'(0));
    model_reset();
    repeat (hold_cycles) @(negedge clk);
    rst_n = 1'b1;
    step_body();
  endtask

  task automatic clear_acks();
    obs_acks[0] = 0;
    obs_acks[1] = 0;
  endtask

  initial begin
    int n;
    logic [31:0] a0;
    for (int i = 0; i < 2; i++) begin
      cyc_d[i] = 0; stb_d[i] = 0; we_d[i] = 0; adr_d[i] = '0; dat_d[i] = '0;
      sel_d[i] = '0; cti_d[i] = '0; bte_d[i] = '0; remain[i] = 0;
    end
    ack_d = 0;
    sdat_d = '0;
    apply();
    model_reset();
    clear_acks();

    // both requesters from the first cycle after reset
    mode[0] = 1; mode[1] = 1; ack_pct = 100;
    do_reset(3);
    @(posedge clk); #1;
    chk("t1_first_owner", 32'(owner), 32'(2'b01));
    for (n = 0; n < 100 && owner != 2'b10; n++) step();
    chk("t1_reader_acks_before_switch", 32'(obs_acks[0]), 32'(MAXB));
    chk("t1_writer_got_bus", 32'(owner), 32'(2'b10));

    // writer alone, five writes then release
    mode[0] = 0; mode[1] = 0;
    repeat (4) step();
    clear_acks();
    mode[1] = 3; remain[1] = 5; ack_pct = 60;
    for (n = 0; n < 200 && remain[1] > 0; n++) step();
    repeat (3) step();
    chk("t2_writer_acks", 32'(obs_acks[1]), 32'(5));
    chk("t2_reader_acks", 32'(obs_acks[0]), 32'(0));
    chk("t2_idle_owner", 32'(owner), 32'(2'b00));

    // reader alone past the burst limit, then writer arrives
    mode[0] = 1; mode[1] = 0; ack_pct = 100;
    repeat (40) step();
    chk("t3_reader_keeps_bus", 32'(owner), 32'(2'b01));
    mode[1] = 1;
    n = 0;
    do begin step(); n++; end while (owner != 2'b10 && n < 10);
    chk("t3_preempt_latency", 32'(n), 32'(3));

    // slave stalls while writer waits at the last burst slot
    mode[0] = 1; mode[1] = 0; ack_pct = 100;
    for (n = 0; n < 100 && !(m_own == 0 && m_cnt == MAXB - 1); n++) step();
    chk("t4_reached_last_slot", 32'(m_own == 0 && m_cnt == MAXB - 1), 32'(1));
    mode[1] = 1; ack_pct = 0;
    step();
    a0 = adr_d[0];
    repeat (9) begin
      step();
      chk("t4_adr_stable", m_if.adr, a0);
      chk("t4_no_switch", 32'(owner), 32'(2'b01));
    end
    ack_pct = 100;
    n = 0;
    do begin step(); n++; end while (owner != 2'b10 && n < 10);
    chk("t4_switch_after_ack", 32'(n), 32'(3));

    // reset in the middle of traffic
    mode[0] = 1; mode[1] = 1; ack_pct = 50;
    repeat (7) step();
    do_reset(2);
    @(posedge clk); #1;
    chk("t5_reader_wins_after_reset", 32'(owner), 32'(2'b01));

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if (k % 50 == 0) begin
        for (int i = 0; i < 2; i++) begin
          mode[i] = $urandom_range(3);
          remain[i] = $urandom_range(20, 1);
        end
        ack_pct = $urandom_range(100, 20);
      end
      step();
    end

`ifdef WSHB_ARB_FIXED_PRIO_EN
    mode[0] = 1; mode[1] = 1; ack_pct = 100;
    do_reset(2);
    clear_acks();
    repeat (1000) step();
    chk("t6_writer_starved", 32'(obs_acks[1]), 32'(0));
    chk("t6_reader_owner", 32'(owner), 32'(2'b01));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
